// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_miss_ctrl
//  Purpose  : Miss handler for the write-back, direct-mapped M-stage data
//             cache. It detects a miss and writes back a dirty victim line.
//             It then refills the line one word per memory handshake. While
//             it is busy it holds the whole pipeline frozen.
//  Ports    : clk, rst_n          clock / async active-low reset
//             req_valid_i         M-stage load or store present
//             req_addr_i          M-stage byte address
//             hit_i, dirty_i      tag-array lookup result for the indexed line
//             victim_tag_i        tag currently stored at the indexed line
//             mem_ack_i           memory accepted/returned one word
//             mem_req_o/we_o      memory word request / 1 = write-back
//             mem_addr_o          word-aligned memory address
//             word_idx_o          data-array word select
//             refill_we_o         write returned word into data array
//             tag_we_o            write new tag, set valid, clear dirty
//             stall_all_m_o       freeze every pipeline stage
//  Revision : 1.0  initial release
// ============================================================================
module dcache_miss_ctrl #(
   parameter  int AW         = 32,
   parameter  int LINE_WORDS = 4,
   parameter  int INDEX_W    = 6,
   localparam int CNT_W      = $clog2(LINE_WORDS),
   localparam int OFF_W      = CNT_W + 2,
   localparam int TAG_W      = AW - INDEX_W - OFF_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid_i,
   input  logic [AW-1:0]    req_addr_i,
   input  logic             hit_i,
   input  logic             dirty_i,
   input  logic [TAG_W-1:0] victim_tag_i,
   input  logic             mem_ack_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [AW-1:0]    mem_addr_o,
   output logic [CNT_W-1:0] word_idx_o,
   output logic             refill_we_o,
   output logic             tag_we_o,
   output logic             stall_all_m_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WB     = 2'd1,
      S_REFILL = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t               state_q,  state_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;
   logic [TAG_W-1:0]     tag_q,    tag_d;
   logic [TAG_W-1:0]     vtag_q,   vtag_d;
   logic [INDEX_W-1:0]   index_q,  index_d;

   logic                 w_miss;
   logic                 w_last;
   logic                 w_unused_offset;

   // Byte/word offset of the request is irrelevant: the whole line moves.
   assign w_unused_offset = ^req_addr_i[OFF_W-1:0];

   // Gated by rst_n so that every output is 0 while reset is held, even if
   // the pipeline keeps presenting a missing access.
   assign w_miss = rst_n & req_valid_i & ~hit_i;
   assign w_last = (cnt_q == CNT_W'(LINE_WORDS - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;
      vtag_d  = vtag_q;
      index_d = index_q;
      case (state_q)
         S_IDLE: begin
            if (w_miss) begin
               // Latch the line identity so req_addr_i may wander afterwards.
               state_d = dirty_i ? S_WB : S_REFILL;
               cnt_d   = '0;
               tag_d   = req_addr_i[AW-1 -: TAG_W];
               index_d = req_addr_i[OFF_W +: INDEX_W];
               vtag_d  = victim_tag_i;
            end
         end
         S_WB: begin
            if (mem_ack_i) begin
               if (w_last) begin
                  state_d = S_REFILL;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end
         S_REFILL: begin
            if (mem_ack_i) begin
               if (w_last) begin
                  state_d = S_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            // One settle cycle so the re-lookup sees the freshly written tag.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tag_q   <= '0;
         vtag_q  <= '0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         vtag_q  <= vtag_d;
         index_q <= index_d;
      end
   end

   always_comb begin
      mem_req_o     = (state_q == S_WB) || (state_q == S_REFILL);
      mem_we_o      = (state_q == S_WB);
      mem_addr_o    = '0;
      if (state_q == S_WB) begin
         mem_addr_o = {vtag_q, index_q, cnt_q, 2'b00};
      end else if (state_q == S_REFILL) begin
         mem_addr_o = {tag_q, index_q, cnt_q, 2'b00};
      end
      word_idx_o    = cnt_q;
      refill_we_o   = (state_q == S_REFILL) && mem_ack_i;
      tag_we_o      = (state_q == S_REFILL) && mem_ack_i && w_last;
      stall_all_m_o = (state_q != S_IDLE) || w_miss;
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_miss_ctrl
//  Purpose  : Self-checking bench for dcache_miss_ctrl. The reference keeps
//             a queue of outstanding memory transfers built when a miss is
//             seen, and derives every expected output from the queue head.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_miss_ctrl;

   localparam int AW  = 32;
   localparam int LW  = 4;
   localparam int IW  = 6;
   localparam int CW  = 2;
   localparam int TW  = AW - IW - CW - 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid_i;
   logic [AW-1:0] req_addr_i;
   logic          hit_i;
   logic          dirty_i;
   logic [TW-1:0] victim_tag_i;
   logic          mem_ack_i;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [CW-1:0] word_idx_o;
   logic          refill_we_o;
   logic          tag_we_o;
   logic          stall_all_m_o;

   always #5 clk = ~clk;

   dcache_miss_ctrl #(.AW(AW), .LINE_WORDS(LW), .INDEX_W(IW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid_i),
      .req_addr_i    (req_addr_i),
      .hit_i         (hit_i),
      .dirty_i       (dirty_i),
      .victim_tag_i  (victim_tag_i),
      .mem_ack_i     (mem_ack_i),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .word_idx_o    (word_idx_o),
      .refill_we_o   (refill_we_o),
      .tag_we_o      (tag_we_o),
      .stall_all_m_o (stall_all_m_o)
   );

   // ---------------- reference model: queue of pending transfers ----------
   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [CW-1:0] idx;
   } xfer_t;

   xfer_t         q_exp[$];
   int            done_pend;

   int            n_tests;
   int            n_fail;
   int            stall_cnt;
   int            tagwe_cnt;
   int            rwe_cnt;
   logic [AW-1:0] addr_log[$];
   logic          we_log[$];

   function automatic bit busy();
      return (q_exp.size() > 0) || (done_pend != 0);
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [38:0] outs();
      return {stall_all_m_o, mem_req_o, mem_we_o, mem_addr_o, word_idx_o, refill_we_o, tag_we_o};
   endfunction

   // Build the transfer list a miss must produce: optional write-back of the
   // victim line, then the refill of the requested line, in word order.
   task automatic model_miss(input logic [AW-1:0] a, input logic dirty, input logic [TW-1:0] vt);
      xfer_t x;
      if (dirty) begin
         for (int w = 0; w < LW; w++) begin
            x.we   = 1'b1;
            x.addr = {vt, a[9:4], 4'b0000} + AW'(w * 4);
            x.idx  = CW'(w);
            q_exp.push_back(x);
         end
      end
      for (int w = 0; w < LW; w++) begin
         x.we   = 1'b0;
         x.addr = {a[AW-1:4], 4'b0000} + AW'(w * 4);
         x.idx  = CW'(w);
         q_exp.push_back(x);
      end
   endtask

   // One clock cycle: drive inputs just after negedge, compare, then advance.
   task automatic cyc(input logic req, input logic hit, input logic dirty, input logic ack,
                      input logic [AW-1:0] a, input logic [TW-1:0] vt, input string name);
      logic [38:0] e;
      req_valid_i  = req;
      hit_i        = hit;
      dirty_i      = dirty;
      mem_ack_i    = ack;
      req_addr_i   = a;
      victim_tag_i = vt;
      #1;
      if (q_exp.size() > 0)
         e = {1'b1, 1'b1, q_exp[0].we, q_exp[0].addr, q_exp[0].idx,
              ack & ~q_exp[0].we, ack & ~q_exp[0].we & (q_exp.size() == 1)};
      else if (done_pend != 0)
         e = {1'b1, 38'b0};
      else
         e = {req & ~hit, 38'b0};
      check(name, 64'(outs()), 64'(e));
      if (stall_all_m_o) stall_cnt++;
      if (tag_we_o)      tagwe_cnt++;
      if (refill_we_o)   rwe_cnt++;
      if (mem_req_o && mem_ack_i) begin
         addr_log.push_back(mem_addr_o);
         we_log.push_back(mem_we_o);
      end
      @(posedge clk);
      if (q_exp.size() > 0) begin
         if (ack) begin
            void'(q_exp.pop_front());
            if (q_exp.size() == 0) done_pend = 1;
         end
      end else if (done_pend != 0) begin
         done_pend = 0;
      end else if (req && !hit) begin
         model_miss(a, dirty, vt);
      end
      @(negedge clk);
   endtask

   // Assert reset at the current point of the cycle; outputs must clear at once.
   task automatic do_reset(input string name);
      rst_n = 1'b0;
      #1;
      check(name, 64'(outs()), 64'd0);
      q_exp.delete();
      done_pend = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic clear_logs();
      stall_cnt = 0;
      tagwe_cnt = 0;
      rwe_cnt   = 0;
      addr_log.delete();
      we_log.delete();
   endtask

   // Full miss: one miss cycle, ack every (gap+1)-th busy cycle, then a hit.
   task automatic run_miss(input logic [AW-1:0] a, input logic dirty, input logic [TW-1:0] vt,
                           input int gap, input bit toggle, input string name);
      int k;
      logic [AW-1:0] aa;
      k = 0;
      cyc(1'b1, 1'b0, dirty, 1'b0, a, vt, {name, "_miss"});
      for (int i = 0; i < 200 && busy(); i++) begin
         aa = toggle ? AW'($urandom) : a;
         cyc(1'b1, 1'b0, dirty, (k % (gap + 1)) == gap, aa, vt, {name, "_busy"});
         k++;
      end
      if (busy()) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got busy expected idle", name);
         q_exp.delete();
         done_pend = 0;
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0, a, vt, {name, "_rehit"});
   endtask

   typedef struct {
      logic req;
      logic hit;
      logic dirty;
      logic ack;
      logic exp_stall;
   } vec_t;

   vec_t tbl[8];

   initial begin
      logic [AW-1:0] exp_a[$];
      n_tests = 0;
      n_fail  = 0;
      done_pend = 0;
      clear_logs();

      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

      // Reset state
      rst_n = 1'b0;
      req_valid_i = 1'b0; req_addr_i = '0; hit_i = 1'b0; dirty_i = 1'b0;
      victim_tag_i = '0; mem_ack_i = 1'b0;
      #1;
      check("reset_state", 64'(outs()), 64'd0);
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Idle-state vectors, including spurious acks; miss rows only check the
      // same-cycle stall and are then aborted by reset.
      for (int i = 0; i < 8; i++) begin
         req_valid_i = tbl[i].req;
         hit_i       = tbl[i].hit;
         dirty_i     = tbl[i].dirty;
         mem_ack_i   = tbl[i].ack;
         req_addr_i  = 32'h0000_4560;
         #1;
         check($sformatf("table_%0d", i),
               64'({stall_all_m_o, mem_req_o, mem_we_o, refill_we_o, tag_we_o}),
               64'({tbl[i].exp_stall, 4'b0000}));
         if (tbl[i].exp_stall) begin
            do_reset($sformatf("table_%0d_rst", i));
         end else begin
            @(posedge clk); @(negedge clk);
         end
      end

      // Hit for 5 cycles: no stall, no memory traffic
      clear_logs();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1234, '0, "hit");
      check("hit_stall_cnt", 64'(stall_cnt), 64'd0);

      // Clean miss at 0x1234, ack every cycle
      clear_logs();
      run_miss(32'h0000_1234, 1'b0, '0, 0, 1'b0, "clean");
      check("clean_stall_cnt", 64'(stall_cnt), 64'd6);
      check("clean_rwe_cnt",   64'(rwe_cnt),   64'd4);
      check("clean_tagwe_cnt", 64'(tagwe_cnt), 64'd1);
      exp_a = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
      check("clean_nxfer", 64'(addr_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
         check($sformatf("clean_addr_%0d", i), 64'(addr_log[i]), 64'(exp_a[i]));
         check($sformatf("clean_we_%0d", i),   64'(we_log[i]),   64'd0);
      end

      // Dirty miss, victim tag 5: write-back then refill
      clear_logs();
      run_miss(32'h0000_1234, 1'b1, TW'(5), 0, 1'b0, "dirty");
      check("dirty_stall_cnt", 64'(stall_cnt), 64'd10);
      check("dirty_tagwe_cnt", 64'(tagwe_cnt), 64'd1);
      exp_a = '{32'h1630, 32'h1634, 32'h1638, 32'h163C,
                32'h1230, 32'h1234, 32'h1238, 32'h123C};
      check("dirty_nxfer", 64'(addr_log.size()), 64'd8);
      for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
         check($sformatf("dirty_addr_%0d", i), 64'(addr_log[i]), 64'(exp_a[i]));
         check($sformatf("dirty_we_%0d", i),   64'(we_log[i]),   (i < 4) ? 64'd1 : 64'd0);
      end

      // Slow memory with req_addr_i toggling mid-refill
      clear_logs();
      run_miss(32'h0000_ABC8, 1'b0, TW'(3), 3, 1'b1, "slow");
      check("slow_stall_cnt", 64'(stall_cnt), 64'd18);
      check("slow_tagwe_cnt", 64'(tagwe_cnt), 64'd1);

      // Reset during the 3rd refill word
      clear_logs();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2000, '0, "rst_miss");
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000, '0, "rst_w0");
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000, '0, "rst_w1");
      mem_ack_i = 1'b0;
      do_reset("rst_mid_outputs");
      check("rst_no_tagwe", 64'(tagwe_cnt), 64'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_2000, '0, "rst_idle_after");

      // Randomized traffic against the reference
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             AW'($urandom), TW'($urandom), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
